soc_mem_arbiter: RTL and testbench

Shares the single port of the SoC 4096×32 block-RAM memory (`soc_mem`) between up to four requesters, for example CPU instruction fetch, CPU load/store and a DMA engine. It uses round-robin arbitration. It tracks the one-cycle read latency and returns read data to the requester that issued the read. Optionally, it sweeps the memory to zero after reset before granting anyone. It sits directly in front of `soc_mem` and drives its `addra`/`dia`/`wea`/`rsta` inputs.

---
 rtl/soc_mem_pkg.sv | 24 ++
 rtl/soc_mem_arbiter_rr_pick.sv | 41 ++++
 rtl/soc_mem_arbiter.sv | 158 +++++++++++++++
 tb/tb_soc_mem_arbiter.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/soc_mem_pkg.sv
// ---------------------------------------------------------------------------
// soc_mem_pkg
// Shared definitions for the SoC block-RAM (soc_mem) and its front-end
// arbiter: FSM state encoding, default memory geometry, the largest
// supported requester count, and an index-width helper.
// ---------------------------------------------------------------------------
package soc_mem_pkg;

    // Arbiter FSM: clearing sweep after reset, then normal arbitration.
    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } arb_state_e;

    localparam int SOC_MEM_AW       = 12;
    localparam int SOC_MEM_DW       = 32;
    localparam int SOC_MEM_NREQ_MAX = 4;

    // Width of an index into n requesters; never narrower than one bit.
    function automatic int soc_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/soc_mem_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker. The search starts one position above
// the last winner (ptr) and wraps, so the most recent winner has lowest
// priority on the next pick.
//
// Parameters: N  - number of requesters
//             IW - width of ptr / idx
// Ports:
//   req  in  N   request vector
//   ptr  in  IW  index of the previous winner
//   gnt  out N   one-hot grant (all-zero when nobody requests)
//   idx  out IW  index of the winner
//   vld  out 1   a winner exists
// ---------------------------------------------------------------------------
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          vld
);

    always_comb begin
        gnt = '0;
        idx = '0;
        vld = 1'b0;
        // k runs 1..N so the previous winner itself is visited last.
        for (int k = 1; k <= N; k++) begin
            if (!vld && req[(int'(ptr) + k) % N]) begin
                vld                      = 1'b1;
                gnt[(int'(ptr) + k) % N] = 1'b1;
                idx                      = IW'((int'(ptr) + k) % N);
            end
        end
    end

endmodule

// File: rtl/soc_mem_arbiter.sv
// ---------------------------------------------------------------------------
// soc_mem_arbiter
// Shares the single port of soc_mem between NREQ requesters with
// round-robin arbitration. Grants are combinational in the cycle the
// request is taken; read data comes back one cycle later, tagged with the
// requester that issued the read.
//
// Build option: define SOC_MEM_ARB_CLEAR_EN to compile in a zero-fill sweep
// of the whole memory after reset, during which no requester is granted.
//
// Ports:
//   clka         in   clock
//   rsta_n       in   synchronous active-low reset
//   req_i        in   NREQ       per-requester request
//   we_i         in   NREQ*BW    per-requester byte write enables (0 = read)
//   addr_i       in   NREQ*AW    per-requester word address
//   wdata_i      in   NREQ*DW    per-requester write data
//   gnt_o        out  NREQ       one-hot accept (combinational)
//   rvalid_o     out  NREQ       one-hot read data valid
//   rdata_o      out  DW         read data, qualified by rvalid_o
//   init_done_o  out  1          arbitration enabled
//   mem_addra    out  AW         soc_mem address
//   mem_dia      out  DW         soc_mem write data
//   mem_wea      out  BW         soc_mem byte write enables
//   mem_rsta     out  1          soc_mem output reset (active-high)
//   mem_doa      in   DW         soc_mem read data
// ---------------------------------------------------------------------------
module soc_mem_arbiter
    import soc_mem_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int AW   = SOC_MEM_AW,
    parameter int DW   = SOC_MEM_DW,
    parameter int BW   = DW / 8
) (
    input  logic               clka,
    input  logic               rsta_n,
    input  logic [NREQ-1:0]    req_i,
    input  logic [NREQ*BW-1:0] we_i,
    input  logic [NREQ*AW-1:0] addr_i,
    input  logic [NREQ*DW-1:0] wdata_i,
    output logic [NREQ-1:0]    gnt_o,
    output logic [NREQ-1:0]    rvalid_o,
    output logic [DW-1:0]      rdata_o,
    output logic               init_done_o,
    output logic [AW-1:0]      mem_addra,
    output logic [DW-1:0]      mem_dia,
    output logic [BW-1:0]      mem_wea,
    output logic               mem_rsta,
    input  logic [DW-1:0]      mem_doa
);

    localparam int IW = soc_idx_w(NREQ);

`ifdef SOC_MEM_ARB_CLEAR_EN
    localparam arb_state_e RST_STATE = ST_INIT;
    logic [AW-1:0] cnt_q, cnt_d;
`else
    localparam arb_state_e RST_STATE = ST_RUN;
`endif

    arb_state_e      state_q, state_d;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [NREQ-1:0] tag_q, tag_d;
    logic            init_done_q;
    logic            mem_rsta_q;
    logic [AW-1:0]   addr_q, addr_d;

    logic [NREQ-1:0] pick_gnt;
    logic [IW-1:0]   pick_idx;
    logic            pick_vld;
    logic            arb_en;
    logic [AW-1:0]   addr_sel;
    logic [DW-1:0]   wdata_sel;
    logic [BW-1:0]   we_sel;

    rr_pick #(
        .N  (NREQ),
        .IW (IW)
    ) u_rr_pick (
        .req (req_i),
        .ptr (rr_ptr_q),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .vld (pick_vld)
    );

    // Payload of the current winner (only meaningful when pick_vld).
    assign addr_sel  = addr_i [pick_idx*AW +: AW];
    assign wdata_sel = wdata_i[pick_idx*DW +: DW];
    assign we_sel    = we_i   [pick_idx*BW +: BW];

    // Reset is synchronous, but grants and writes must already be quiet in
    // the cycle reset is asserted, so they are gated with rsta_n directly.
    assign arb_en = (state_q == ST_RUN) && rsta_n;

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        tag_d     = '0;
        gnt_o     = '0;
        mem_addra = addr_q;
        mem_dia   = '0;
        mem_wea   = '0;
`ifdef SOC_MEM_ARB_CLEAR_EN
        cnt_d     = cnt_q;
        if ((state_q == ST_INIT) && rsta_n) begin
            mem_addra = cnt_q;
            mem_wea   = '1;
            cnt_d     = cnt_q + 1'b1;
            if (cnt_q == '1) begin
                state_d = ST_RUN;
            end
        end
`endif
        if (arb_en && pick_vld) begin
            gnt_o     = pick_gnt;
            mem_addra = addr_sel;
            mem_dia   = wdata_sel;
            mem_wea   = we_sel;
            rr_ptr_d  = pick_idx;
            if (we_sel == '0) begin
                tag_d = pick_gnt;
            end
        end
        // With no access the memory keeps seeing the last address.
        addr_d = mem_addra;
    end

    always_ff @(posedge clka) begin
        mem_rsta_q <= ~rsta_n;
        addr_q     <= addr_d;
        if (!rsta_n) begin
            state_q     <= RST_STATE;
            rr_ptr_q    <= IW'(NREQ - 1);
            tag_q       <= '0;
            init_done_q <= 1'b0;
`ifdef SOC_MEM_ARB_CLEAR_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            tag_q       <= tag_d;
            init_done_q <= (state_q == ST_RUN);
`ifdef SOC_MEM_ARB_CLEAR_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    // A tag left over from before a reset must not surface while reset is low.
    assign rvalid_o    = tag_q & {NREQ{rsta_n}};
    assign rdata_o     = mem_doa;
    assign init_done_o = init_done_q;
    assign mem_rsta    = mem_rsta_q;

endmodule

// File: tb/tb_soc_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_soc_mem_arbiter
// Drives soc_mem_arbiter (NREQ=3) in front of a behavioural 4096x32
// byte-writable block RAM and compares grants, read-valid tags and read
// data with a reference model built from the arbitration rules.
// Honours SOC_MEM_ARB_CLEAR_EN for the init latency and memory contents.
// ---------------------------------------------------------------------------
module tb_soc_mem_arbiter;

    localparam int NREQ  = 3;
    localparam int AW    = 12;
    localparam int DW    = 32;
    localparam int BW    = 4;
    localparam int DEPTH = 1 << AW;

`ifdef SOC_MEM_ARB_CLEAR_EN
    localparam bit CLEAR    = 1'b1;
    localparam int EXP_INIT = DEPTH + 1;
`else
    localparam bit CLEAR    = 1'b0;
    localparam int EXP_INIT = 1;
`endif

    logic               clka;
    logic               rsta_n;
    logic [NREQ-1:0]    tb_req;
    logic [NREQ*BW-1:0] tb_we;
    logic [NREQ*AW-1:0] tb_addr;
    logic [NREQ*DW-1:0] tb_wdata;
    logic [NREQ-1:0]    gnt_o;
    logic [NREQ-1:0]    rvalid_o;
    logic [DW-1:0]      rdata_o;
    logic               init_done_o;
    logic [AW-1:0]      mem_addra;
    logic [DW-1:0]      mem_dia;
    logic [BW-1:0]      mem_wea;
    logic               mem_rsta;
    logic [DW-1:0]      mem_doa;

    soc_mem_arbiter #(
        .NREQ (NREQ),
        .AW   (AW),
        .DW   (DW),
        .BW   (BW)
    ) dut (
        .clka        (clka),
        .rsta_n      (rsta_n),
        .req_i       (tb_req),
        .we_i        (tb_we),
        .addr_i      (tb_addr),
        .wdata_i     (tb_wdata),
        .gnt_o       (gnt_o),
        .rvalid_o    (rvalid_o),
        .rdata_o     (rdata_o),
        .init_done_o (init_done_o),
        .mem_addra   (mem_addra),
        .mem_dia     (mem_dia),
        .mem_wea     (mem_wea),
        .mem_rsta    (mem_rsta),
        .mem_doa     (mem_doa)
    );

    initial clka = 1'b0;
    always #5 clka = ~clka;

    // Behavioural soc_mem: read-first, one-cycle registered read data.
    logic [DW-1:0] mem_arr [0:DEPTH-1];

    initial begin
        for (int i = 0; i < DEPTH; i++) mem_arr[i] <= 32'hA5A5_0000 | i;
    end

    always @(posedge clka) begin
        if (mem_rsta) mem_doa <= '0;
        else          mem_doa <= mem_arr[mem_addra];
        for (int b = 0; b < BW; b++) begin
            if (mem_wea[b]) mem_arr[mem_addra][b*8 +: 8] <= mem_dia[b*8 +: 8];
        end
    end

    // Reference model state
    logic [DW-1:0] ref_mem [0:DEPTH-1];
    int            rr_last;
    int            last_win;
    int            n_checks;
    int            n_fail;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clka);
        #1;
    endtask

    task automatic set_req(input int r, input logic [3:0] we, input logic [11:0] a,
                           input logic [31:0] d);
        tb_req[r]             = 1'b1;
        tb_we[r*BW +: BW]     = we;
        tb_addr[r*AW +: AW]   = a;
        tb_wdata[r*DW +: DW]  = d;
    endtask

    // Next winner: first requester strictly after the previous winner, wrapping.
    function automatic int model_pick();
        for (int k = 1; k <= NREQ; k++) begin
            if (tb_req[(rr_last + k) % NREQ]) return (rr_last + k) % NREQ;
        end
        return -1;
    endfunction

    // One arbitration cycle: inputs are already driven; checks the grant,
    // lets the edge happen, then checks the read response.
    task automatic step();
        int            w;
        logic [2:0]    exp_tag;
        logic [31:0]   exp_data;
        logic [3:0]    we;
        logic [11:0]   a;
        logic [31:0]   d;
        #1;
        w        = model_pick();
        exp_tag  = '0;
        exp_data = '0;
        check("gnt", {29'd0, gnt_o}, (w >= 0) ? (32'd1 << w) : 32'd0);
        if (w >= 0) begin
            we = tb_we[w*BW +: BW];
            a  = tb_addr[w*AW +: AW];
            d  = tb_wdata[w*DW +: DW];
            if (we == 4'b0000) begin
                exp_tag  = 3'(1 << w);
                exp_data = ref_mem[a];
            end else begin
                for (int b = 0; b < BW; b++)
                    if (we[b]) ref_mem[a][b*8 +: 8] = d[b*8 +: 8];
            end
            rr_last = w;
        end
        last_win = w;
        tick();
        check("rvalid", {29'd0, rvalid_o}, {29'd0, exp_tag});
        if (exp_tag != 3'b000) check("rdata", rdata_o, exp_data);
    endtask

    task automatic do_reset();
        int cnt;
        rsta_n = 1'b0;
        tb_req = '1;
        tb_we  = '0;
        #1;
        check("rst_gnt", {29'd0, gnt_o}, 32'd0);
        check("rst_rvalid", {29'd0, rvalid_o}, 32'd0);
        check("rst_wea", {28'd0, mem_wea}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_init_done", {31'd0, init_done_o}, 32'd0);
            check("rst_mem_rsta", {31'd0, mem_rsta}, 32'd1);
            check("rst_rvalid_hold", {29'd0, rvalid_o}, 32'd0);
        end
        tb_req = '0;
        rsta_n = 1'b1;
        cnt    = 0;
        while (cnt < EXP_INIT + 100) begin
            tick();
            cnt++;
            if (init_done_o === 1'b1) break;
        end
        check("init_done_latency", cnt, EXP_INIT);
        check("mem_rsta_released", {31'd0, mem_rsta}, 32'd0);
        rr_last = NREQ - 1;
        if (CLEAR) begin
            for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        end
    endtask

    int exp_order [6];

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rr_last  = NREQ - 1;
        last_win = -1;
        tb_req   = '0;
        tb_we    = '0;
        tb_addr  = '0;
        tb_wdata = '0;
        rsta_n   = 1'b0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'hA5A5_0000 | i;

        // Reset and optional clear sweep, then read a mid-memory word.
        do_reset();
        set_req(0, 4'b0000, 12'h7FF, '0);
        step();
        check("read_7ff", rdata_o, CLEAR ? 32'h0 : 32'hA5A5_07FF);
        tb_req = '0;

        // Single write then read from requester 0.
        set_req(0, 4'b1111, 12'h010, 32'hDEADBEEF);
        step();
        set_req(0, 4'b0000, 12'h010, '0);
        step();
        check("wr_rd_data", rdata_o, 32'hDEADBEEF);
        tb_req = '0;

        // Byte enables.
        set_req(0, 4'b1111, 12'h030, 32'h11223344);
        step();
        set_req(0, 4'b0010, 12'h030, 32'hAABBCCDD);
        step();
        set_req(0, 4'b0000, 12'h030, '0);
        step();
        check("byte_en_data", rdata_o, 32'h1122CC44);
        tb_req = '0;

        // Round robin: park the pointer on requester 2, then all three read.
        set_req(2, 4'b0000, 12'h012, '0);
        step();
        set_req(0, 4'b0000, 12'h010, '0);
        set_req(1, 4'b0000, 12'h011, '0);
        set_req(2, 4'b0000, 12'h012, '0);
        exp_order = '{0, 1, 2, 0, 1, 2};
        for (int i = 0; i < 6; i++) begin
            step();
            check("rr_order", last_win, exp_order[i]);
        end
        tb_req = '0;
        step();

        // Contention: requester 1 writes 0x5 while requester 0 reads 0x20.
        set_req(2, 4'b0000, 12'h012, '0);
        step();
        tb_req = '0;
        set_req(1, 4'b1111, 12'h020, 32'h5);
        set_req(0, 4'b0000, 12'h020, '0);
        step();
        check("contend_first", last_win, 0);
        check("contend_old_data", rdata_o, CLEAR ? 32'h0 : 32'hA5A5_0020);
        tb_req[0] = 1'b0;
        step();
        check("contend_second", last_win, 1);
        tb_req = '0;
        set_req(0, 4'b0000, 12'h020, '0);
        step();
        check("contend_new_data", rdata_o, 32'h5);
        tb_req = '0;

        // Randomized traffic with held-until-granted requests.
        for (int n = 0; n < 300; n++) begin
            for (int r = 0; r < NREQ; r++) begin
                if (!tb_req[r] && ($urandom_range(0, 1) == 1)) begin
                    set_req(r,
                            ($urandom_range(0, 1) == 1) ? 4'b0000 : 4'($urandom_range(1, 15)),
                            12'h040 + 12'($urandom_range(0, 7)),
                            $urandom);
                end
            end
            step();
            if (last_win >= 0) tb_req[last_win] = 1'b0;
        end
        tb_req = '0;

        // Reset while a read is in flight: its rvalid must never appear.
        set_req(1, 4'b0000, 12'h011, '0);
        #1;
        check("midrd_gnt", {29'd0, gnt_o}, 32'd2);
        tick();
        rsta_n = 1'b0;
        #1;
        check("midrd_rvalid_supp", {29'd0, rvalid_o}, 32'd0);
        do_reset();
        check("midrd_rvalid_after", {29'd0, rvalid_o}, 32'd0);
        set_req(1, 4'b0000, 12'h011, '0);
        set_req(0, 4'b0000, 12'h010, '0);
        step();
        check("midrd_first_winner", last_win, 0);
        tb_req = '0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
